arm7tdmi_perf_counter_reader: RTL and testbench

ARM7TDMI_PERF_COUNTER_READER -- requirements
Module: arm7tdmi_perf_counter_reader

---
 rtl/arm7tdmi_perf_counter_reader_pkg.sv | 45 ++++
 rtl/arm7tdmi_perf_snapshot_bank.sv | 58 +++++
 rtl/arm7tdmi_perf_counter_reader.sv | 147 ++++++++++++++
 tb/tb_arm7tdmi_perf_counter_reader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm7tdmi_perf_counter_reader_pkg.sv
// Shared types and constants for the performance-counter reader.
// Command encodings, FSM states, counter index map and the status-word helper.
package arm7tdmi_perf_counter_reader_pkg;

    localparam int PERF_NUM_COUNTERS = 17;
    localparam int PERF_STATUS_IDX   = 31;
    localparam int PERF_CNT_W        = 32;

    typedef enum logic [1:0] {
        CMD_READ       = 2'b00,
        CMD_SNAPSHOT   = 2'b01,
        CMD_RESET      = 2'b10,
        CMD_READ_DELTA = 2'b11
    } perf_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } perf_state_e;

    // Fixed counter ordering presented by the monitor on cnt_in.
    localparam int IDX_IC_ACC       = 0;
    localparam int IDX_IC_HIT       = 1;
    localparam int IDX_IC_MISS      = 2;
    localparam int IDX_IC_EVICT     = 3;
    localparam int IDX_DC_ACC       = 4;
    localparam int IDX_DC_HIT       = 5;
    localparam int IDX_DC_MISS      = 6;
    localparam int IDX_DC_EVICT     = 7;
    localparam int IDX_DC_WRITE     = 8;
    localparam int IDX_DC_WRITEBACK = 9;
    localparam int IDX_COH_INVAL    = 10;
    localparam int IDX_COH_CONFLICT = 11;
    localparam int IDX_MMU_ACC      = 12;
    localparam int IDX_MMU_HIT      = 13;
    localparam int IDX_MMU_MISS     = 14;
    localparam int IDX_MMU_FAULT    = 15;
    localparam int IDX_MMU_ASID     = 16;

    function automatic logic [PERF_CNT_W-1:0] perf_status_word(input logic ovf, input logic snap);
        return {30'b0, ovf, snap};
    endfunction

endpackage

// File: rtl/arm7tdmi_perf_snapshot_bank.sv
// Current/previous snapshot banks with indexed read of the value and its delta.
// Latency: capture/clear on the clock edge; read ports are combinational.
module arm7tdmi_perf_snapshot_bank
    import arm7tdmi_perf_counter_reader_pkg::*;
#(
    parameter int NUM_COUNTERS = PERF_NUM_COUNTERS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_capture,
    input  logic                         i_clear,
    input  logic [NUM_COUNTERS*32-1:0]   i_cnt,
    input  logic [4:0]                   i_idx,
    output logic [31:0]                  o_cur,
    output logic [31:0]                  o_delta
);

    logic [31:0] r_cur  [NUM_COUNTERS];
    logic [31:0] r_prev [NUM_COUNTERS];
    logic [31:0] w_cur_sel;
    logic [31:0] w_prev_sel;

    // Previous bank takes the old current value on the same edge the new capture lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_cur[i]  <= '0;
                r_prev[i] <= '0;
            end
        end else if (i_clear) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_cur[i]  <= '0;
                r_prev[i] <= '0;
            end
        end else if (i_capture) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_prev[i] <= r_cur[i];
                r_cur[i]  <= i_cnt[32*i +: 32];
            end
        end
    end

    // Out-of-range indices select zero; range errors are reported by the caller.
    always_comb begin
        w_cur_sel  = '0;
        w_prev_sel = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (i_idx == 5'(i)) begin
                w_cur_sel  = r_cur[i];
                w_prev_sel = r_prev[i];
            end
        end
    end

    assign o_cur   = w_cur_sel;
    assign o_delta = w_cur_sel - w_prev_sel;

endmodule

// File: rtl/arm7tdmi_perf_counter_reader.sv
// Host command front-end for the perf monitor: snapshot, read, delta read, clear.
// Latency: response valid 2 cycles after acceptance; one command in flight, held until rsp_ready.
module arm7tdmi_perf_counter_reader
    import arm7tdmi_perf_counter_reader_pkg::*;
#(
    parameter int NUM_COUNTERS = PERF_NUM_COUNTERS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_COUNTERS*32-1:0]   cnt_in,
    input  logic                         cnt_overflow,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [1:0]                   req_cmd,
    input  logic [4:0]                   req_idx,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_data,
    output logic                         rsp_err,
    output logic                         perf_reset_out,
    output logic                         snap_valid,
    output logic                         ovf_irq
);

    localparam logic [5:0] LP_NUM = 6'(NUM_COUNTERS);

    perf_state_e r_state;
    perf_state_e w_state_nxt;
    perf_cmd_e   r_cmd;
    logic [4:0]  r_idx;
    logic [31:0] r_rsp_data;
    logic        r_rsp_err;
    logic        r_snap_valid;
    logic        r_ovf_sticky;

    logic        w_accept;
    logic        w_exec;
    logic        w_capture;
    logic        w_clear;
    logic        w_in_range;
    logic        w_is_status;
    logic [31:0] w_cur;
    logic [31:0] w_delta;
    logic [31:0] w_rsp_data;
    logic        w_rsp_err;

    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign w_exec      = (r_state == ST_EXEC);
    assign w_capture   = w_exec && (r_cmd == CMD_SNAPSHOT);
    assign w_clear     = w_exec && (r_cmd == CMD_RESET);
    assign w_in_range  = ({1'b0, r_idx} < LP_NUM);
    assign w_is_status = (r_idx == 5'(PERF_STATUS_IDX));

    arm7tdmi_perf_snapshot_bank #(
        .NUM_COUNTERS (NUM_COUNTERS)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_capture (w_capture),
        .i_clear   (w_clear),
        .i_cnt     (cnt_in),
        .i_idx     (r_idx),
        .o_cur     (w_cur),
        .o_delta   (w_delta)
    );

    // Response is formed from pre-edge bank contents, so a READ never sees its own capture.
    always_comb begin
        w_rsp_data = '0;
        w_rsp_err  = 1'b0;
        unique case (r_cmd)
            CMD_SNAPSHOT: w_rsp_data = 32'(NUM_COUNTERS);
            CMD_RESET:    w_rsp_data = '0;
            CMD_READ: begin
                if (w_is_status) begin
                    w_rsp_data = perf_status_word(r_ovf_sticky, r_snap_valid);
                end else if (w_in_range && r_snap_valid) begin
                    w_rsp_data = w_cur;
                end else begin
                    w_rsp_err = 1'b1;
                end
            end
            CMD_READ_DELTA: begin
                if (w_in_range && r_snap_valid) begin
                    w_rsp_data = w_delta;
                end else begin
                    w_rsp_err = 1'b1;
                end
            end
            default: w_rsp_err = 1'b1;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (req_valid) w_state_nxt = ST_EXEC;
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd        <= CMD_READ;
            r_idx        <= '0;
            r_rsp_data   <= '0;
            r_rsp_err    <= 1'b0;
            r_snap_valid <= 1'b0;
            r_ovf_sticky <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cmd <= perf_cmd_e'(req_cmd);
                r_idx <= req_idx;
            end
            if (w_exec) begin
                r_rsp_data <= w_rsp_data;
                r_rsp_err  <= w_rsp_err;
            end
            if (w_clear) begin
                r_snap_valid <= 1'b0;
            end else if (w_capture) begin
                r_snap_valid <= 1'b1;
            end
            // A same-cycle overflow wins over the clear so no event is lost.
            r_ovf_sticky <= (r_ovf_sticky && !w_clear) || cnt_overflow;
        end
    end

    assign req_ready      = (r_state == ST_IDLE);
    assign rsp_valid      = (r_state == ST_RESP);
    assign rsp_data       = r_rsp_data;
    assign rsp_err        = r_rsp_err;
    assign perf_reset_out = w_clear;
    assign snap_valid     = r_snap_valid;
    assign ovf_irq        = r_ovf_sticky;

endmodule

// File: tb/tb_arm7tdmi_perf_counter_reader.sv
// Scoreboard bench for arm7tdmi_perf_counter_reader: commands push expected responses,
// returned responses are popped and compared inline by each scenario task.
module tb_arm7tdmi_perf_counter_reader;

    localparam int N = 17;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*32-1:0] cnt_in;
    logic            cnt_overflow;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_cmd;
    logic [4:0]      req_idx;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [31:0]     rsp_data;
    logic            rsp_err;
    logic            perf_reset_out;
    logic            snap_valid;
    logic            ovf_irq;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_cur  [N];
    logic [31:0] m_prev [N];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          pulse_cnt = 0;

    arm7tdmi_perf_counter_reader #(.NUM_COUNTERS(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cnt_in         (cnt_in),
        .cnt_overflow   (cnt_overflow),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_cmd        (req_cmd),
        .req_idx        (req_idx),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_err        (rsp_err),
        .perf_reset_out (perf_reset_out),
        .snap_valid     (snap_valid),
        .ovf_irq        (ovf_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (perf_reset_out === 1'b1) pulse_cnt++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_cur[i]  = '0;
            m_prev[i] = '0;
        end
    endtask

    task automatic model_snapshot();
        for (int i = 0; i < N; i++) begin
            m_prev[i] = m_cur[i];
            m_cur[i]  = cnt_in[32*i +: 32];
        end
    endtask

    // Drives one command until accepted; returns in the EXEC cycle (#1 after the accept edge).
    task automatic send(input logic [1:0] cmd, input logic [4:0] idx,
                        input logic [31:0] ed, input logic ee, output int acc);
        int n = 0;
        req_cmd   = cmd;
        req_idx   = idx;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        sb.push_back('{data: ed, err: ee});
        if (req_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL accept_timeout: req_ready=%b, required 1", req_ready);
            req_valid = 1'b0;
            acc = -1000;
            return;
        end
        acc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [31:0] d, output logic e, output int seen);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (rsp_valid !== 1'b1) begin
            tests++; fails++;
            $display("FAIL rsp_timeout: rsp_valid=%b, required 1", rsp_valid);
            d = 'x; e = 1'bx; seen = -1000;
            return;
        end
        d    = rsp_data;
        e    = rsp_err;
        seen = cyc;
        @(posedge clk); #1;
    endtask

    task automatic transact(input logic [1:0] cmd, input logic [4:0] idx,
                            input logic [31:0] ed, input logic ee,
                            output logic [31:0] od, output logic oe,
                            output exp_t x, output int acc, output int lat);
        int seen;
        send(cmd, idx, ed, ee, acc);
        get_rsp(od, oe, seen);
        x   = sb.pop_front();
        lat = seen - acc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_cmd = '0; req_idx = '0;
        rsp_ready = 1'b1; cnt_overflow = 1'b0; cnt_in = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        tests++; if (req_ready !== 1'b1)      begin fails++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        tests++; if (rsp_valid !== 1'b0)      begin fails++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
        tests++; if (rsp_data !== 32'h0)      begin fails++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data); end
        tests++; if (rsp_err !== 1'b0)        begin fails++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
        tests++; if (perf_reset_out !== 1'b0) begin fails++; $display("FAIL rst_perf_reset_out: got %b want 0", perf_reset_out); end
        tests++; if (snap_valid !== 1'b0)     begin fails++; $display("FAIL rst_snap_valid: got %b want 0", snap_valid); end
        tests++; if (ovf_irq !== 1'b0)        begin fails++; $display("FAIL rst_ovf_irq: got %b want 0", ovf_irq); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_errors_before_snapshot();
        logic [31:0] d; logic e; exp_t x; int acc, lat;
        transact(2'b00, 5'd3, 32'h0, 1'b1, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL read3_no_snap: got %h/%b want %h/%b", d, e, x.data, x.err); end
        transact(2'b11, 5'd0, 32'h0, 1'b1, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL delta0_no_snap: got %h/%b want %h/%b", d, e, x.data, x.err); end
        transact(2'b00, 5'd31, 32'h0, 1'b0, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL status_no_snap: got %h/%b want %h/%b", d, e, x.data, x.err); end
    endtask

    task automatic test_snapshot_read();
        logic [31:0] d; logic e; exp_t x; int acc, lat;
        cnt_in[31:0] = 32'd100;
        transact(2'b01, 5'd0, 32'd17, 1'b0, d, e, x, acc, lat);
        model_snapshot();
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL snapshot_rsp: got %h/%b want %h/%b", d, e, x.data, x.err); end
        tests++; if (snap_valid !== 1'b1) begin fails++; $display("FAIL snap_valid_set: got %b want 1", snap_valid); end
        transact(2'b00, 5'd0, 32'd100, 1'b0, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL read0: got %h/%b want %h/%b", d, e, x.data, x.err); end
        tests++; if (lat !== 2) begin fails++; $display("FAIL read_latency: got %0d want 2", lat); end
        transact(2'b11, 5'd0, 32'd100, 1'b0, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL delta0_first: got %h/%b want %h/%b", d, e, x.data, x.err); end
    endtask

    task automatic test_index_bounds();
        logic [31:0] d; logic e; exp_t x; int acc, lat;
        transact(2'b00, 5'd20, 32'h0, 1'b1, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL read20: got %h/%b want %h/%b", d, e, x.data, x.err); end
        transact(2'b00, 5'd17, 32'h0, 1'b1, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL read17: got %h/%b want %h/%b", d, e, x.data, x.err); end
        transact(2'b11, 5'd31, 32'h0, 1'b1, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL delta31: got %h/%b want %h/%b", d, e, x.data, x.err); end
        transact(2'b00, 5'd16, m_cur[16], 1'b0, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL read16: got %h/%b want %h/%b", d, e, x.data, x.err); end
    endtask

    task automatic test_delta_wrap();
        logic [31:0] d; logic e; exp_t x; int acc, lat;
        cnt_in[5*32 +: 32] = 32'hFFFF_FFF0;
        transact(2'b01, 5'd0, 32'd17, 1'b0, d, e, x, acc, lat);
        model_snapshot();
        cnt_in[5*32 +: 32] = 32'h0000_0010;
        transact(2'b01, 5'd0, 32'd17, 1'b0, d, e, x, acc, lat);
        model_snapshot();
        transact(2'b11, 5'd5, 32'h20, 1'b0, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL delta_wrap: got %h/%b want %h/%b", d, e, x.data, x.err); end
        transact(2'b00, 5'd5, 32'h10, 1'b0, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL read5_after_wrap: got %h/%b want %h/%b", d, e, x.data, x.err); end
    endtask

    task automatic test_random_banks();
        logic [31:0] d; logic e; exp_t x; int acc, lat;
        logic [4:0] idx;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) cnt_in[32*i +: 32] = $urandom;
            transact(2'b01, 5'd0, 32'd17, 1'b0, d, e, x, acc, lat);
            model_snapshot();
            tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL rnd_snapshot: got %h/%b want %h/%b", d, e, x.data, x.err); end
            for (int k = 0; k < 4; k++) begin
                idx = 5'($urandom_range(0, N - 1));
                transact(2'b00, idx, m_cur[idx], 1'b0, d, e, x, acc, lat);
                tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL rnd_read idx%0d: got %h/%b want %h/%b", idx, d, e, x.data, x.err); end
                transact(2'b11, idx, m_cur[idx] - m_prev[idx], 1'b0, d, e, x, acc, lat);
                tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL rnd_delta idx%0d: got %h/%b want %h/%b", idx, d, e, x.data, x.err); end
            end
        end
    endtask

    task automatic test_ovf_and_reset();
        logic [31:0] d; logic e; exp_t x; int acc, lat;
        cnt_overflow = 1'b1;
        @(posedge clk); #1;
        cnt_overflow = 1'b0;
        tests++; if (ovf_irq !== 1'b1) begin fails++; $display("FAIL ovf_irq_set: got %b want 1", ovf_irq); end
        transact(2'b00, 5'd31, 32'h3, 1'b0, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL status_ovf: got %h/%b want %h/%b", d, e, x.data, x.err); end
        pulse_cnt = 0;
        transact(2'b10, 5'd0, 32'h0, 1'b0, d, e, x, acc, lat);
        model_clear();
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL reset_rsp: got %h/%b want %h/%b", d, e, x.data, x.err); end
        tests++; if (pulse_cnt !== 1) begin fails++; $display("FAIL perf_reset_pulse: got %0d cycles want 1", pulse_cnt); end
        tests++; if (ovf_irq !== 1'b0) begin fails++; $display("FAIL ovf_irq_clr: got %b want 0", ovf_irq); end
        tests++; if (snap_valid !== 1'b0) begin fails++; $display("FAIL snap_valid_clr: got %b want 0", snap_valid); end
        transact(2'b00, 5'd31, 32'h0, 1'b0, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL status_after_reset: got %h/%b want %h/%b", d, e, x.data, x.err); end
        transact(2'b00, 5'd0, 32'h0, 1'b1, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL read_after_reset: got %h/%b want %h/%b", d, e, x.data, x.err); end
        cnt_in[7*32 +: 32] = 32'h1234_5678;
        transact(2'b01, 5'd0, 32'd17, 1'b0, d, e, x, acc, lat);
        model_snapshot();
        transact(2'b11, 5'd7, m_cur[7] - m_prev[7], 1'b0, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL delta_prev_cleared: got %h/%b want %h/%b", d, e, x.data, x.err); end
    endtask

    task automatic test_ovf_during_reset();
        logic [31:0] d; logic e; exp_t x; int acc, seen;
        send(2'b10, 5'd0, 32'h0, 1'b0, acc);
        cnt_overflow = 1'b1;
        @(posedge clk); #1;
        cnt_overflow = 1'b0;
        get_rsp(d, e, seen);
        x = sb.pop_front();
        model_clear();
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL reset_ovf_rsp: got %h/%b want %h/%b", d, e, x.data, x.err); end
        tests++; if (ovf_irq !== 1'b1) begin fails++; $display("FAIL ovf_set_wins: got %b want 1", ovf_irq); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic e; exp_t x; int acc1, acc2, lat;
        transact(2'b01, 5'd0, 32'd17, 1'b0, d, e, x, acc1, lat);
        model_snapshot();
        transact(2'b00, 5'd31, 32'h3, 1'b0, d, e, x, acc2, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL b2b_status: got %h/%b want %h/%b", d, e, x.data, x.err); end
        tests++; if (acc2 - acc1 !== 3) begin fails++; $display("FAIL b2b_spacing: got %0d want 3", acc2 - acc1); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0; exp_t x; int acc, n;
        rsp_ready = 1'b0;
        send(2'b00, 5'd9, m_cur[9], 1'b0, acc);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        d0 = rsp_data;
        x  = sb.pop_front();
        tests++; if (d0 !== x.data || rsp_err !== x.err) begin fails++; $display("FAIL bp_rsp: got %h/%b want %h/%b", d0, rsp_err, x.data, x.err); end
        req_cmd = 2'b01; req_idx = 5'd0; req_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_req_ready c%0d: got %b want 0", c, req_ready); end
            tests++; if (rsp_valid !== 1'b1 || rsp_data !== x.data) begin fails++; $display("FAIL bp_hold c%0d: got %b/%h want 1/%h", c, rsp_valid, rsp_data, x.data); end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got %b/%b want 0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_reset_mid_exec();
        int acc, stray;
        logic [31:0] d; logic e; exp_t x; int lat;
        for (int i = 0; i < N; i++) cnt_in[32*i +: 32] = $urandom;
        send(2'b01, 5'd0, 32'd17, 1'b0, acc);
        void'(sb.pop_front());
        #2 rst_n = 1'b0;
        #1;
        model_clear();
        tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_hs: got %b/%b want 1/0", req_ready, rsp_valid); end
        tests++; if (rsp_data !== 32'h0 || rsp_err !== 1'b0) begin fails++; $display("FAIL mid_rst_rsp: got %h/%b want 0/0", rsp_data, rsp_err); end
        tests++; if (perf_reset_out !== 1'b0 || snap_valid !== 1'b0 || ovf_irq !== 1'b0) begin
            fails++; $display("FAIL mid_rst_flags: got %b%b%b want 000", perf_reset_out, snap_valid, ovf_irq); end
        @(negedge clk); rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b0) stray++;
        end
        tests++; if (stray !== 0) begin fails++; $display("FAIL mid_rst_no_rsp: got %0d cycles valid want 0", stray); end
        transact(2'b00, 5'd0, 32'h0, 1'b1, d, e, x, acc, lat);
        tests++; if (d !== x.data || e !== x.err) begin fails++; $display("FAIL read_after_mid_rst: got %h/%b want %h/%b", d, e, x.data, x.err); end
    endtask

    initial begin
        test_reset();
        test_errors_before_snapshot();
        test_snapshot_read();
        test_index_bounds();
        test_delta_wrap();
        test_random_banks();
        test_ovf_and_reset();
        test_ovf_during_reset();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_exec();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
